sobel_avalon_slave_regs: RTL and testbench
==========================================

# sobel_avalon_slave_regs

Avalon-MM slave register block that terminates the bus opposite the design's Avalon master, so the host can configure and monitor the Sobel core. It holds the source/destination SRAM base addresses and image dimensions, issues a one-cycle start pulse to the core controller, and tracks busy/done/error status. Reads use a fixed two-cycle latency, matching the master's read-data timing.

## Interface
- ADDR_W, 3, word-address width of the register window
- DATA_W, 32, bus data width (all registers are DATA_W bits)

- clk  in  1  system clock, all logic on rising edge
- n_rst  in  1  asynchronous, active-high reset (n_rst=1 resets immediately; release synchronous to clk)
- address  in  ADDR_W  register word address
- read  in  1  read request, one cycle per access
- write  in  1  write request, one cycle per access
- writedata  in  DATA_W  write data
- readdata  out  DATA_W  read data, valid only with readdatavalid
- readdatavalid  out  1  read data strobe, exactly one pulse per accepted read
- core_busy  in  1  level from the Sobel controller, high while processing
- core_done  in  1  one-cycle pulse from the Sobel controller at frame end
- start  out  1  one-cycle start pulse to the Sobel controller
- src_addr  out  32  SRAM base address of the input image
- dst_addr  out  32  SRAM base address of the output image
- img_width  out  16  image width in pixels
- img_height  out  16  image height in pixels
- irq  out  1  level interrupt, present only with SOBEL_SLAVE_IRQ_EN

## Operation
- Register map (word addresses):
  - 0 CTRL: bit0 START (write-1 pulses start; reads 0), bit1 IRQ_EN (R/W)
  - 1 STATUS: bit0 BUSY (RO, mirrors core_busy), bit1 DONE (sticky, W1C), bit2 ERR (sticky, W1C)
  - 2 SRC: src_addr R/W
  - 3 DST: dst_addr R/W
  - 4 DIM: [31:16] img_height, [15:0] img_width, R/W
  - 5–7: reads return 0, writes ignored
- No waitrequest; every request is accepted on the cycle it is presented.
- START write with core_busy=0: start=1 on the next cycle; DONE cleared in the same cycle.
- START write with core_busy=1, or with start already high: no pulse, ERR set.
- core_done=1: DONE set. Same-cycle W1C of DONE and core_done=1: DONE stays 1, so set wins. Same rule applies to ERR.
- Simultaneous read and write: both accepted. Write updates the register. Read returns the value held before that write.
- All outputs and registers reset to 0: readdata, readdatavalid, start, src_addr, dst_addr, img_width, img_height, IRQ_EN, DONE, ERR, irq.

## Timing
- Read pipeline has two stages. A read at cycle N samples the register in cycle N and drives readdatavalid=1 with readdata at cycle N+2.
- readdata is 0 whenever readdatavalid=0.
- Back-to-back reads every cycle are supported at full throughput, with one readdatavalid per read, in order.
- Writes take effect at the rising edge ending cycle N. Register outputs change in cycle N+1, and start pulses in cycle N+1 for exactly one cycle.
- Reset asserted mid-read flushes the pipeline: no readdatavalid for any read issued before or during reset.

## Configuration
- SOBEL_SLAVE_IRQ_EN defined:
  - irq is a registered output equal to IRQ_EN & (DONE | ERR).
  - irq rises one cycle after the triggering bit sets.
  - irq falls one cycle after W1C clears the bit or IRQ_EN is cleared.
- SOBEL_SLAVE_IRQ_EN undefined:
  - irq is tied to 0.
  - CTRL bit1 is not stored: it reads 0 and writes to it are ignored.

## Test plan
- Reset, then read addresses 0–7 back-to-back: 8 readdatavalid pulses at cycles N+2..N+9, all data 0.
- Write SRC=0x0000_1000, DST=0x0002_0000, DIM=0x00F0_0140, then read back: values match; outputs show img_width=320, img_height=240.
- core_busy=0, write CTRL=1: start high for exactly one cycle, one cycle after the write. Repeat with core_busy=1: no start, STATUS reads 0x5.
- Pulse core_done in the same cycle as a write of STATUS=0x2: a later STATUS read returns DONE=1. A second write of 0x2 then clears it, and STATUS reads 0x0.
- Read STATUS and write STATUS=0x2 in the same cycle with DONE=1: the read returns 0x2, and the next read returns 0x0.
- With SOBEL_SLAVE_IRQ_EN defined: write CTRL=0x2, then pulse core_done. irq rises one cycle after DONE sets and falls one cycle after W1C. Without the macro, irq stays 0 and CTRL reads 0.

Source files
------------

// File: rtl/sobel_avalon_slave_regs.sv
`default_nettype none
// ============================================================================
// Module   : sobel_avalon_slave_regs
// Purpose  : Avalon-MM slave register block for the Sobel core. Holds the
//            source/destination base addresses and image dimensions, issues
//            a one-cycle start pulse and tracks busy/done/error status.
//            Reads have a fixed two-cycle latency.
// Options  : SOBEL_SLAVE_IRQ_EN - when defined, CTRL bit1 (IRQ_EN) is stored
//            and irq = IRQ_EN & (DONE | ERR), registered. Otherwise irq = 0.
// Notes    : DATA_W must be at least 32; the SRC/DST/DIM fields are 32 bits.
// Revision : 1.0 - initial release
// ============================================================================
module sobel_avalon_slave_regs #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid,
  input  logic              core_busy,
  input  logic              core_done,
  output logic              start,
  output logic [31:0]       src_addr,
  output logic [31:0]       dst_addr,
  output logic [15:0]       img_width,
  output logic [15:0]       img_height,
  output logic              irq
);

  localparam logic [ADDR_W-1:0] c_addr_ctrl   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] c_addr_status = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] c_addr_src    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] c_addr_dst    = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] c_addr_dim    = ADDR_W'(4);

  logic              start_q, start_d;
  logic [31:0]       src_q, src_d;
  logic [31:0]       dst_q, dst_d;
  logic [15:0]       width_q, width_d;
  logic [15:0]       height_q, height_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              rd_vld1_q, rd_vld1_d;
  logic [DATA_W-1:0] rd_data1_q, rd_data1_d;
  logic              readdatavalid_q, readdatavalid_d;
  logic [DATA_W-1:0] readdata_q, readdata_d;

  logic              w_wr_ctrl, w_wr_status, w_wr_src, w_wr_dst, w_wr_dim;
  logic              w_start_req, w_start_ok, w_start_err;
  logic              w_irq_en;
  logic [DATA_W-1:0] w_rd_mux;

  // Address decode and start-request qualification
  always_comb begin
    w_wr_ctrl   = write && (address == c_addr_ctrl);
    w_wr_status = write && (address == c_addr_status);
    w_wr_src    = write && (address == c_addr_src);
    w_wr_dst    = write && (address == c_addr_dst);
    w_wr_dim    = write && (address == c_addr_dim);
    w_start_req = w_wr_ctrl && writedata[0];
    // A start while the core is busy or a pulse is still out is refused
    w_start_ok  = w_start_req && !core_busy && !start_q;
    w_start_err = w_start_req && (core_busy || start_q);
  end

  // Read mux samples the pre-write register values of the current cycle
  always_comb begin
    w_rd_mux = '0;
    case (address)
      c_addr_ctrl:   w_rd_mux = DATA_W'({w_irq_en, 1'b0});
      c_addr_status: w_rd_mux = DATA_W'({err_q, done_q, core_busy});
      c_addr_src:    w_rd_mux = DATA_W'(src_q);
      c_addr_dst:    w_rd_mux = DATA_W'(dst_q);
      c_addr_dim:    w_rd_mux = DATA_W'({height_q, width_q});
      default:       w_rd_mux = '0;
    endcase
  end

  // Next-state for configuration, status and the two-stage read pipeline
  always_comb begin
    start_d  = w_start_ok;
    src_d    = w_wr_src ? writedata[31:0] : src_q;
    dst_d    = w_wr_dst ? writedata[31:0] : dst_q;
    width_d  = w_wr_dim ? writedata[15:0] : width_q;
    height_d = w_wr_dim ? writedata[31:16] : height_q;

    // Sticky bits: clears first, so a same-cycle set takes priority
    done_d = done_q;
    if (w_wr_status && writedata[1]) done_d = 1'b0;
    if (w_start_ok)                  done_d = 1'b0;
    if (core_done)                   done_d = 1'b1;

    err_d = err_q;
    if (w_wr_status && writedata[2]) err_d = 1'b0;
    if (w_start_err)                 err_d = 1'b1;

    rd_vld1_d       = read;
    rd_data1_d      = read ? w_rd_mux : '0;
    readdatavalid_d = rd_vld1_q;
    readdata_d      = rd_vld1_q ? rd_data1_q : '0;
  end

  // State registers; reset also flushes any read in flight
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      start_q         <= 1'b0;
      src_q           <= '0;
      dst_q           <= '0;
      width_q         <= '0;
      height_q        <= '0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
      rd_vld1_q       <= 1'b0;
      rd_data1_q      <= '0;
      readdatavalid_q <= 1'b0;
      readdata_q      <= '0;
    end else begin
      start_q         <= start_d;
      src_q           <= src_d;
      dst_q           <= dst_d;
      width_q         <= width_d;
      height_q        <= height_d;
      done_q          <= done_d;
      err_q           <= err_d;
      rd_vld1_q       <= rd_vld1_d;
      rd_data1_q      <= rd_data1_d;
      readdatavalid_q <= readdatavalid_d;
      readdata_q      <= readdata_d;
    end
  end

`ifdef SOBEL_SLAVE_IRQ_EN
  logic irq_en_q, irq_en_d;
  logic irq_q, irq_d;

  // IRQ enable is written through CTRL bit1; irq follows status one cycle later
  always_comb begin
    irq_en_d = w_wr_ctrl ? writedata[1] : irq_en_q;
    irq_d    = irq_en_q & (done_q | err_q);
  end

  // Interrupt enable and registered interrupt output
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign w_irq_en = irq_en_q;
  assign irq      = irq_q;
`else
  assign w_irq_en = 1'b0;
  assign irq      = 1'b0;
`endif

  assign start         = start_q;
  assign src_addr      = src_q;
  assign dst_addr      = dst_q;
  assign img_width     = width_q;
  assign img_height    = height_q;
  assign readdata      = readdata_q;
  assign readdatavalid = readdatavalid_q;

endmodule
`default_nettype wire

// File: tb/tb_sobel_avalon_slave_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_sobel_avalon_slave_regs
// Purpose  : Directed self-checking bench for sobel_avalon_slave_regs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sobel_avalon_slave_regs;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic [2:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        core_busy = 1'b0;
  logic        core_done = 1'b0;
  logic        start;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] img_width, img_height;
  logic        irq;

  int passes = 0;
  int total  = 0;

  sobel_avalon_slave_regs #(.ADDR_W(3), .DATA_W(32)) dut (
    .clk(clk), .n_rst(n_rst), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .readdatavalid(readdatavalid),
    .core_busy(core_busy), .core_done(core_done), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .img_width(img_width),
    .img_height(img_height), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [2:0] a, input logic [31:0] exp);
    address = a; read = 1'b1;
    tick();
    read = 1'b0;
    tick();
    check({tag, "_rdv"}, 32'(readdatavalid), 32'd1);
    check(tag, readdata, exp);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_rdv",   32'(readdatavalid), 32'd0);
    check("rst_rdata", readdata, 32'd0);
    check("rst_start", 32'(start), 32'd0);
    check("rst_src",   src_addr, 32'd0);
    check("rst_dst",   dst_addr, 32'd0);
    check("rst_dim",   {img_height, img_width}, 32'd0);
    check("rst_irq",   32'(irq), 32'd0);
    n_rst = 1'b0;
    tick();

    // Back-to-back reads of all eight addresses: valid in cycles 2..9
    for (int i = 0; i < 10; i++) begin
      read    = (i < 8);
      address = 3'(i);
      tick();
      check("b2b_rdv",   32'(readdatavalid), 32'((i >= 1) && (i <= 8)));
      check("b2b_rdata", readdata, 32'd0);
    end
    read = 1'b0;

    // Configuration registers
    do_write(3'd2, 32'h0000_1000);
    check("src_out", src_addr, 32'h0000_1000);
    do_write(3'd3, 32'h0002_0000);
    do_write(3'd4, 32'h00F0_0140);
    check("dst_out",    dst_addr, 32'h0002_0000);
    check("width_out",  32'(img_width), 32'd320);
    check("height_out", 32'(img_height), 32'd240);
    do_read("src_rd", 3'd2, 32'h0000_1000);
    do_read("dst_rd", 3'd3, 32'h0002_0000);
    do_read("dim_rd", 3'd4, 32'h00F0_0140);
    do_read("res_rd", 3'd6, 32'd0);

    // Start pulse when idle
    check("start_pre", 32'(start), 32'd0);
    do_write(3'd0, 32'h1);
    check("start_pulse", 32'(start), 32'd1);
    tick();
    check("start_end", 32'(start), 32'd0);
    do_read("status_idle", 3'd1, 32'h0);

    // Start refused while busy
    core_busy = 1'b1;
    do_write(3'd0, 32'h1);
    check("start_busy", 32'(start), 32'd0);
    tick();
    check("start_busy2", 32'(start), 32'd0);
    do_read("status_err", 3'd1, 32'h5);
    core_busy = 1'b0;
    do_write(3'd1, 32'h4);
    do_read("status_errclr", 3'd1, 32'h0);

    // Set wins over same-cycle W1C of DONE
    core_done = 1'b1;
    do_write(3'd1, 32'h2);
    core_done = 1'b0;
    do_read("done_setwin", 3'd1, 32'h2);
    do_write(3'd1, 32'h2);
    do_read("done_clr", 3'd1, 32'h0);

    // Simultaneous read and W1C write: read returns pre-write value
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    address = 3'd1; writedata = 32'h2; read = 1'b1; write = 1'b1;
    tick();
    read = 1'b0; write = 1'b0;
    tick();
    check("rw_rdv", 32'(readdatavalid), 32'd1);
    check("rw_old", readdata, 32'h2);
    do_read("rw_new", 3'd1, 32'h0);

    // Second start while the first pulse is still high: refused, ERR set
    address = 3'd0; writedata = 32'h1; write = 1'b1;
    tick();
    check("dbl_start1", 32'(start), 32'd1);
    tick();
    write = 1'b0;
    check("dbl_start2", 32'(start), 32'd0);
    do_read("dbl_status", 3'd1, 32'h4);
    do_write(3'd1, 32'h4);

    // Interrupt behaviour
    do_write(3'd0, 32'h2);
`ifdef SOBEL_SLAVE_IRQ_EN
    do_read("ctrl_irqen", 3'd0, 32'h2);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("irq_lag", 32'(irq), 32'd0);
    tick();
    check("irq_rise", 32'(irq), 32'd1);
    do_write(3'd1, 32'h2);
    check("irq_hold", 32'(irq), 32'd1);
    tick();
    check("irq_fall", 32'(irq), 32'd0);
`else
    do_read("ctrl_noirq", 3'd0, 32'h0);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    tick();
    check("irq_tied0", 32'(irq), 32'd0);
    tick();
    check("irq_tied0b", 32'(irq), 32'd0);
    do_write(3'd1, 32'h2);
`endif

    // Reset mid-read flushes the pipeline
    address = 3'd2; read = 1'b1;
    tick();
    read = 1'b0;
    n_rst = 1'b1;
    #1;
    check("flush_src", src_addr, 32'd0);
    tick();
    check("flush_rdv1", 32'(readdatavalid), 32'd0);
    n_rst = 1'b0;
    tick();
    check("flush_rdv2", 32'(readdatavalid), 32'd0);
    check("flush_rdata", readdata, 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
`default_nettype wire
